// File: rtl/fifo_wr_arbiter_if.sv
// Bus bundle between NUM_REQ write-domain requesters, the arbiter and the FIFO write port.
//   i_req / i_last / i_data : per-requester beat valid, end-of-burst flag and packed data
//   o_gnt                   : one-hot (or zero) beat acceptance back to the requesters
//   i_fifo_full             : same-cycle full flag of the FIFO write-pointer logic
//   o_fifo_wr_en/o_fifo_wdata : FIFO write strobe and word
//   o_busy / o_owner        : burst lock status and current/last owner index
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
) ();
  localparam int unsigned OwnerW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ-1:0]            i_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]            o_gnt;
  logic                          i_fifo_full;
  logic                          o_fifo_wr_en;
  logic [DATA_WIDTH-1:0]         o_fifo_wdata;
  logic                          o_busy;
  logic [OwnerW-1:0]             o_owner;

  modport slave (
    input  i_req, i_last, i_data, i_fifo_full,
    output o_gnt, o_fifo_wr_en, o_fifo_wdata, o_busy, o_owner
  );

  modport master (
    output i_req, i_last, i_data, i_fifo_full,
    input  o_gnt, o_fifo_wr_en, o_fifo_wdata, o_busy, o_owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter for the single write port of an async FIFO.
// A requester owns the port for a whole burst (ended by i_last or after MAX_BURST beats),
// so bursts never interleave in the FIFO.
//   i_wr_clk : write-domain clock
//   i_rst    : synchronous active-high reset
//   io_bus   : requester handshake, FIFO write port and status (see fifo_wr_arbiter_if)
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16
) (
  input logic              i_wr_clk,
  input logic              i_rst,
  fifo_wr_arbiter_if.slave io_bus
);
  localparam int unsigned OwnerW = $clog2(NUM_REQ);
  localparam int unsigned BeatW  = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e              r_state, w_state_d;
  logic [OwnerW-1:0]   r_owner, w_owner_d;
  logic [OwnerW-1:0]   r_last_owner, w_last_owner_d;
  logic [BeatW-1:0]    r_beats, w_beats_d, w_beats_inc;
  logic [OwnerW-1:0]   w_pick;
  logic                w_found;
  logic                w_acc;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [DATA_WIDTH-1:0] w_wdata;

  // Round-robin pick: first set request scanning upward from last_owner+1, wrapping.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && io_bus.i_req[OwnerW'((32'(r_last_owner) + i) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_pick  = OwnerW'((32'(r_last_owner) + i) % NUM_REQ);
      end
    end
  end

  // Owner data mux; driven in every state so the FIFO word is stable ahead of the grant.
  always_comb begin
    w_wdata = io_bus.i_data[DATA_WIDTH-1:0];
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (r_owner == OwnerW'(k)) begin
        w_wdata = io_bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_beats_inc = r_beats + BeatW'(1);

  always_comb begin
    w_state_d      = r_state;
    w_owner_d      = r_owner;
    w_last_owner_d = r_last_owner;
    w_beats_d      = r_beats;
    w_acc          = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|io_bus.i_req) begin
          w_owner_d = w_pick;
          w_beats_d = '0;
          w_state_d = StXfer;
        end
      end
      StXfer: begin
        w_acc = io_bus.i_req[r_owner] & ~io_bus.i_fifo_full;
        if (w_acc) begin
          w_beats_d = w_beats_inc;
          // Release on the burst's final beat or when the beat cap is reached.
          if (io_bus.i_last[r_owner] || (w_beats_inc == BeatW'(MAX_BURST))) begin
            w_last_owner_d = r_owner;
            w_state_d      = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Nothing may be written while reset is held, even mid-burst.
    if (i_rst) begin
      w_acc = 1'b0;
    end
  end

  always_comb begin
    w_gnt          = '0;
    w_gnt[r_owner] = w_acc;
  end

  always_ff @(posedge i_wr_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_owner      <= '0;
      r_last_owner <= OwnerW'(NUM_REQ - 1);
      r_beats      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_owner      <= w_owner_d;
      r_last_owner <= w_last_owner_d;
      r_beats      <= w_beats_d;
    end
  end

  assign io_bus.o_gnt        = w_gnt;
  assign io_bus.o_fifo_wr_en = w_acc;
  assign io_bus.o_fifo_wdata = w_wdata;
  assign io_bus.o_busy       = (r_state == StXfer);
  assign io_bus.o_owner      = r_owner;
endmodule
